// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

   // Arbiter FSM states: IDLE arbitrates, GRANT streams the owner's words.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Widest requester vector the helper below handles.
   localparam int MAX_NREQ = 8;

   // Burst counter width: must hold 0..MAXBURST.
   function automatic int cnt_w(input int maxburst);
      return $clog2(maxburst + 1);
   endfunction

   // One-hot winner: first requester at or after (ptr+1) mod nreq, wrapping.
   function automatic logic [MAX_NREQ-1:0] rr_next(input logic [MAX_NREQ-1:0] req,
                                                   input int unsigned ptr,
                                                   input int unsigned nreq);
      logic [MAX_NREQ-1:0] win;
      logic                found;
      int unsigned         idx;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 1; k <= MAX_NREQ; k++) begin
         if (k <= nreq) begin
            idx = ptr + k;
            if (idx >= nreq) idx = idx - nreq;
            if (!found && req[idx]) begin
               win[idx] = 1'b1;
               found    = 1'b1;
            end
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the slot
// after ptr sits at bit 0, take the lowest set bit, then rotate the index back.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_onehot,
   output logic [IW-1:0]   o_idx,
   output logic            o_any
);

   logic [NREQ-1:0] w_rot;
   logic [IW-1:0]   w_pos;

   // Rotate right by (ptr+1): w_rot[i] is requester (ptr+1+i) mod NREQ.
   always_comb begin
      int j;
      j     = 0;
      w_rot = '0;
      for (int i = 0; i < NREQ; i++) begin
         j = i + int'(i_ptr) + 1;
         if (j >= NREQ) j = j - NREQ;
         w_rot[i] = i_req[j];
      end
   end

   // Priority-encode the rotated vector, lowest position wins.
   always_comb begin
      w_pos = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_rot[i]) w_pos = IW'(i);
      end
   end

   // Rotate the winning position back into requester numbering.
   always_comb begin
      int s;
      s = int'(w_pos) + int'(i_ptr) + 1;
      if (s >= NREQ) s = s - NREQ;
      o_idx    = IW'(s);
      o_any    = |i_req;
      o_onehot = o_any ? (NREQ'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the write side of the async FIFO among NREQ
// requesters. Owner gets up to MAXBURST words per grant; stalls on wfull.
// Handshake: a word of requester i is transferred in a cycle exactly when
// ack[i]=1 (which coincides with winc=1); req[i]/slice i must stay stable
// until that cycle, and may change every accepted cycle afterwards.
// busy mirrors the FSM state (1 = GRANT) for observation.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DSIZE    = 8,
   parameter int MAXBURST = 4
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*DSIZE-1:0] req_data,
   input  logic                  wfull,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic                  busy
);

   localparam int             IW      = $clog2(NREQ);
   localparam int             CW      = cnt_w(MAXBURST);
   localparam logic [CW-1:0]  LAST    = CW'(MAXBURST - 1);
   localparam logic [IW-1:0]  PTR_RST = IW'(NREQ - 1);

   arb_state_t     r_state;
   logic [NREQ-1:0] r_gnt;
   logic [IW-1:0]   r_owner;
   logic [IW-1:0]   r_ptr;
   logic [CW-1:0]   r_cnt;

   arb_state_t     w_state_nx;
   logic [NREQ-1:0] w_gnt_nx;
   logic [IW-1:0]   w_owner_nx;
   logic [IW-1:0]   w_ptr_nx;
   logic [CW-1:0]   w_cnt_nx;
   logic            w_release;

   logic [NREQ-1:0] w_pick_oh;
   logic [IW-1:0]   w_pick_idx;
   logic            w_pick_any;
   logic            w_own_req;
   logic            w_accept;
   logic            w_last;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx),
      .o_any    (w_pick_any)
   );

   assign w_own_req = req[r_owner];
   assign w_accept  = (r_state == GRANT) && w_own_req && !wfull;
   assign w_last    = (r_cnt == LAST);

   // Next-state: arbitrate in IDLE; in GRANT count words, release on last
   // word or when the owner drops its request, hold everything on wfull.
   always_comb begin
      w_state_nx = r_state;
      w_gnt_nx   = r_gnt;
      w_owner_nx = r_owner;
      w_ptr_nx   = r_ptr;
      w_cnt_nx   = r_cnt;
      w_release  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_state_nx = GRANT;
               w_gnt_nx   = w_pick_oh;
               w_owner_nx = w_pick_idx;
               w_cnt_nx   = '0;
            end
         end
         GRANT: begin
            if (w_accept) begin
               if (w_last) w_release = 1'b1;
               else        w_cnt_nx  = r_cnt + CW'(1);
            end else if (!w_own_req) begin
               w_release = 1'b1;
            end
         end
         default: w_state_nx = IDLE;
      endcase
      if (w_release) begin
         w_state_nx = IDLE;
         w_gnt_nx   = '0;
         w_ptr_nx   = r_owner;
         w_cnt_nx   = '0;
      end
   end

   // State registers; reset leaves ptr at NREQ-1 so requester 0 wins first.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_owner <= '0;
         r_ptr   <= PTR_RST;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_gnt   <= w_gnt_nx;
         r_owner <= w_owner_nx;
         r_ptr   <= w_ptr_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // Write strobes are gated by reset so a mid-burst reset never writes.
   assign winc  = w_accept && wrst_n;
   assign ack   = (w_accept && wrst_n) ? r_gnt : '0;
   assign wdata = (r_state == GRANT) ? req_data[int'(r_owner)*DSIZE +: DSIZE] : '0;
   assign gnt   = r_gnt;
   assign busy  = (r_state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed phases from the test plan followed by
// a randomized phase, all checked against a behavioural model of the arbiter
// and a 16-deep FIFO occupancy model that drives wfull.
module tb_fifo_wr_arbiter;

   localparam int NREQ     = 4;
   localparam int DSIZE    = 8;
   localparam int MAXBURST = 4;
   localparam int FDEPTH   = 16;

   // ---------------- clock / reset / DUT ----------------
   logic                  wclk = 1'b0;
   logic                  wrst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*DSIZE-1:0] req_data;
   logic                  wfull;
   logic                  winc;
   logic [DSIZE-1:0]      wdata;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic                  busy;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(
      .NREQ     (NREQ),
      .DSIZE    (DSIZE),
      .MAXBURST (MAXBURST)
   ) dut (
      .wclk     (wclk),
      .wrst_n   (wrst_n),
      .req      (req),
      .req_data (req_data),
      .wfull    (wfull),
      .winc     (winc),
      .wdata    (wdata),
      .gnt      (gnt),
      .ack      (ack),
      .busy     (busy)
   );

   // ---------------- FIFO model / bench state ----------------
   int   occ;
   bit   rd_en;
   bit   force_full;
   assign wfull = force_full || (occ >= FDEPTH);

   // Arbiter reference: who owns the port, words written this grant, last owner.
   bit   m_busy;
   int   m_owner;
   int   m_words;
   int   m_ptr;

   bit   last_acc;
   int   last_owner;
   int   n_wr;
   logic [NREQ-1:0]  prev_gnt;

   int   n_vec;
   int   n_err;

   logic [DSIZE-1:0] exp_q[$];
   logic [DSIZE-1:0] wr_log[$];
   int               gnt_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First requester at or after (p+1) mod NREQ that is requesting, or -1.
   function automatic int rr_win(input logic [NREQ-1:0] r, input int p);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // One clock: check outputs mid-cycle, advance the model, cross the edge.
   task automatic cycle();
      logic [NREQ-1:0]  e_gnt;
      logic [NREQ-1:0]  e_ack;
      logic [DSIZE-1:0] e_wdata;
      bit               acc;
      int               w;
      int               n_occ;
      @(negedge wclk);
      e_gnt   = m_busy ? NREQ'(1 << m_owner) : '0;
      acc     = m_busy && wrst_n && req[m_owner] && !wfull;
      e_ack   = acc ? e_gnt : '0;
      e_wdata = m_busy ? req_data[m_owner*DSIZE +: DSIZE] : '0;
      chk("gnt",   gnt,   e_gnt);
      chk("winc",  winc,  acc);
      chk("ack",   ack,   e_ack);
      chk("wdata", wdata, e_wdata);
      chk("busy",  busy,  m_busy);
      // scoreboard of words entering the FIFO
      if (acc) exp_q.push_back(e_wdata);
      if (winc === 1'b1) begin
         n_wr++;
         wr_log.push_back(wdata);
         if (exp_q.size() > 0) chk("sb_word", wdata, exp_q.pop_front());
         else                  chk("sb_spurious_winc", winc, 1'b0);
      end
      // grant-order log from the observed gnt
      if (gnt !== '0 && prev_gnt === '0) begin
         for (int i = 0; i < NREQ; i++) if (gnt[i] === 1'b1) gnt_log.push_back(i);
      end
      prev_gnt   = gnt;
      last_acc   = acc;
      last_owner = m_owner;
      // arbiter model
      if (!wrst_n) begin
         m_busy  = 1'b0;
         m_words = 0;
         m_ptr   = NREQ - 1;
      end else if (!m_busy) begin
         w = rr_win(req, m_ptr);
         if (w >= 0) begin
            m_busy  = 1'b1;
            m_owner = w;
            m_words = 0;
         end
      end else if (acc) begin
         m_words++;
         if (m_words == MAXBURST) begin
            m_busy = 1'b0;
            m_ptr  = m_owner;
         end
      end else if (!req[m_owner]) begin
         m_busy = 1'b0;
         m_ptr  = m_owner;
      end
      n_occ = occ + (acc ? 1 : 0) - ((rd_en && occ > 0) ? 1 : 0);
      @(posedge wclk);
      #1;
      occ = n_occ;
   endtask

   // Fresh random word for whoever was just acknowledged (streaming).
   task automatic refresh_acked();
      if (last_acc) req_data[last_owner*DSIZE +: DSIZE] = DSIZE'($urandom_range(0, 255));
   endtask

   // Drop all requests and let the arbiter return to IDLE (bounded).
   task automatic drain();
      req = '0;
      for (int i = 0; i < 8 && m_busy; i++) cycle();
      cycle();
      chk("drain_busy", busy, 1'b0);
   endtask

   initial begin
      int base;
      int acks;
      int gbase;
      n_vec = 0; n_err = 0; n_wr = 0;
      occ = 0; rd_en = 1'b1; force_full = 1'b0;
      wrst_n = 1'b0; req = '0; req_data = '0;
      prev_gnt = '0; last_acc = 1'b0; last_owner = 0;
      m_busy = 1'b0; m_owner = 0; m_words = 0; m_ptr = NREQ - 1;
      @(posedge wclk);
      #1;
      // reset state, still in reset
      cycle();
      wrst_n = 1'b1;

      // ---- all four requesting: grants 0,1,2,3,0, bursts of 4 ----
      req_data = $urandom();
      req = 4'b1111;
      gbase = gnt_log.size();
      base = n_wr;
      for (int i = 0; i < 25; i++) begin
         cycle();
         refresh_acked();
      end
      chk("rr_writes", n_wr - base, 20);
      chk("rr_ngrants", gnt_log.size() - gbase, 5);
      if (gnt_log.size() - gbase >= 5) begin
         chk("rr_order0", gnt_log[gbase + 0], 0);
         chk("rr_order1", gnt_log[gbase + 1], 1);
         chk("rr_order2", gnt_log[gbase + 2], 2);
         chk("rr_order3", gnt_log[gbase + 3], 3);
         chk("rr_order4", gnt_log[gbase + 4], 0);
      end
      drain();

      // ---- only requester 2, data 0x21..0x28 streamed ----
      gbase = gnt_log.size();
      base  = wr_log.size();
      req_data[2*DSIZE +: DSIZE] = 8'h21;
      req = 4'b0100;
      acks = 0;
      for (int i = 0; i < 20 && acks < 8; i++) begin
         cycle();
         if (last_acc) begin
            acks++;
            req_data[2*DSIZE +: DSIZE] = DSIZE'(8'h21 + acks);
         end
      end
      req = '0;
      cycle();
      chk("solo_count", wr_log.size() - base, 8);
      for (int i = 0; i < 8; i++) begin
         if (base + i < wr_log.size()) chk("solo_word", wr_log[base + i], 8'h21 + i);
      end
      chk("solo_ngrants", gnt_log.size() - gbase, 2);
      if (gnt_log.size() - gbase >= 2) begin
         chk("solo_g0", gnt_log[gbase], 2);
         chk("solo_g1", gnt_log[gbase + 1], 2);
      end
      drain();

      // ---- owner 1 drops after 2 words, requester 2 waiting ----
      req = 4'b0110;
      acks = 0;
      for (int i = 0; i < 10 && acks < 2; i++) begin
         cycle();
         if (last_acc) begin
            acks++;
            refresh_acked();
         end
      end
      chk("drop_owner", last_owner, 1);
      req[1] = 1'b0;
      base = n_wr;
      cycle();   // release cycle
      cycle();   // dead IDLE cycle, re-arbitration
      chk("drop_nowrite", n_wr - base, 0);
      cycle();
      chk("drop_regrant", gnt, 4'b0100);
      drain();

      // ---- wfull for 5 cycles in the middle of a burst ----
      req = 4'b0001;
      base = n_wr;
      acks = 0;
      for (int i = 0; i < 10 && acks < 2; i++) begin
         cycle();
         if (last_acc) begin
            acks++;
            refresh_acked();
         end
      end
      force_full = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      chk("full_stall_writes", n_wr - base, 2);
      chk("full_gnt_held", gnt, 4'b0001);
      force_full = 1'b0;
      for (int i = 0; i < 10 && acks < 4; i++) begin
         cycle();
         if (last_acc) begin
            acks++;
            refresh_acked();
         end
      end
      chk("full_burst_total", n_wr - base, 4);
      req = '0;
      cycle();
      chk("full_released", busy, 1'b0);
      drain();

      // ---- reset pulled mid-burst ----
      req = 4'b1111;
      for (int i = 0; i < 10 && !(m_busy && m_words >= 1); i++) cycle();
      chk("rst_in_grant", busy, 1'b1);
      wrst_n = 1'b0;
      base = n_wr;
      cycle();
      chk("rst_no_write", n_wr - base, 0);
      wrst_n = 1'b1;
      cycle();
      chk("rst_idle_gnt", gnt_log.size() > 0, 1'b1);
      cycle();
      chk("rst_regrant0", gnt, 4'b0001);
      drain();

      // ---- fill the 16-deep FIFO from requester 3 with reads stopped ----
      for (int i = 0; i < 40 && occ > 0; i++) cycle();
      chk("fill_empty_start", wfull, 1'b0);
      rd_en = 1'b0;
      req = 4'b1000;
      base = n_wr;
      for (int i = 0; i < 40; i++) begin
         cycle();
         refresh_acked();
      end
      chk("fill_16", n_wr - base, 16);
      chk("fill_full", wfull, 1'b1);
      rd_en = 1'b1;
      cycle();
      rd_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         refresh_acked();
      end
      chk("fill_17th", n_wr - base, 17);
      drain();
      rd_en = 1'b1;

      // ---- randomized traffic ----
      for (int c = 0; c < 400; c++) begin
         cycle();
         wrst_n     = ($urandom_range(0, 99) != 0);
         force_full = ($urandom_range(0, 7) == 0);
         rd_en      = ($urandom_range(0, 1) == 1);
         for (int r = 0; r < NREQ; r++) begin
            if (last_acc && last_owner == r) begin
               if ($urandom_range(0, 3) == 0) req[r] = 1'b0;
               req_data[r*DSIZE +: DSIZE] = DSIZE'($urandom_range(0, 255));
            end else if (!req[r]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req[r] = 1'b1;
                  req_data[r*DSIZE +: DSIZE] = DSIZE'($urandom_range(0, 255));
               end
            end else if (m_busy && m_owner == r && $urandom_range(0, 15) == 0) begin
               req[r] = 1'b0;
            end
         end
      end
      wrst_n = 1'b1;
      drain();
      chk("sb_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the 16x8 async FIFO among NREQ requesters in the write clock domain. It sequences winc/wdata, grants each requester a bounded burst, and stalls cleanly on wfull. It sits directly in front of the FIFO's wdata/winc/wfull pins; the read side is untouched.

## Interface
- NREQ, 4, number of requesters (2..8)
- DSIZE, 8, data width; matches FIFO DSIZE
- MAXBURST, 4, max words per grant (>=1)

- wclk  in  1  write-domain clock; all logic on rising edge
- wrst_n  in  1  reset; one clock; reset is synchronous and active-low
- req  in  NREQ  req[i]=1: requester i has a word on its data slice
- req_data  in  NREQ*DSIZE  slice i = req_data[i*DSIZE +: DSIZE]
- wfull  in  1  FIFO full flag (write domain)
- winc  out  1  FIFO write enable
- wdata  out  DSIZE  FIFO write data
- gnt  out  NREQ  one-hot current owner, registered
- ack  out  NREQ  ack[i]=1: requester i's word is written this cycle
- busy  out  1  state != IDLE

## Operation
- State: IDLE, GRANT. Registers: state, gnt, owner index, last-owner pointer ptr, burst counter cnt (width clog2(MAXBURST+1)).
- IDLE: if |req, pick first requester at or after (ptr+1) mod NREQ with req=1, wrapping; load gnt one-hot, cnt=0, go GRANT. Else stay.
- GRANT, accept = req[owner] & ~wfull:
  - winc = accept; wdata = owner slice; ack = gnt when accept, else 0.
  - accept and cnt==MAXBURST-1: last word written; ptr=owner, gnt=0, go IDLE.
  - accept otherwise: cnt+1, stay.
  - ~req[owner]: release without writing; ptr=owner, gnt=0, go IDLE.
  - req[owner] & wfull: stall; cnt, gnt held; winc=0.
- Non-owner requests are ignored until re-arbitration; they must hold req/data stable until ack.
- Requester may change data every accepted cycle (streaming).

## Timing
- Reset (edge with wrst_n=0): state=IDLE, gnt=0, cnt=0, ptr=NREQ-1 (requester 0 wins first). Outputs: winc=0, ack=0, gnt=0, busy=0, wdata=0.
- winc, ack, wdata are combinational from registered gnt and inputs req/wfull; winc and ack forced to 0 while wrst_n=0 so a mid-burst reset never writes.
- Arbitration latency: req rises in cycle N (IDLE) -> gnt valid and first write possible in cycle N+1.
- One dead IDLE cycle between consecutive grants; full MAXBURST throughput = MAXBURST/(MAXBURST+1).
- wfull is sampled the same cycle as winc: no write is issued while wfull=1; no overflow possible.
- Simultaneous release and new requests: release cycle completes, re-arbitration in following IDLE cycle using updated ptr.
- MAXBURST=1: every accept releases.

## Structure
- Package fifo_arb_pkg: state enum (IDLE, GRANT), localparam for counter width, function rr_next(req, ptr) returning one-hot winner.
- Sub-module rr_pick: combinational rotate/priority-encode/rotate-back; inputs req, ptr; outputs one-hot and index. Top holds FSM, counters, muxing.

## Test plan
- Reset then req=4'b1111 held, wfull=0, MAXBURST=4: grants 0,1,2,3,0 in order; each 4 consecutive winc, one idle cycle between; ack matches gnt.
- Only req[2]=1, data 0x21..0x28 streamed: two bursts of 4 to requester 2, wdata sequence 0x21..0x28 exact, ptr wraps back to 2.
- Owner 1 drops req after 2 words: release, cnt reset, next grant to requester 2 (req[2]=1) after one IDLE cycle; no spurious winc.
- wfull asserted mid-burst for 5 cycles: winc=0 and ack=0 throughout, gnt unchanged, burst resumes with remaining words; total writes into the FIFO never exceed 16 before reads.
- wrst_n pulled low during GRANT for one edge: winc=0 in reset cycle, afterwards gnt=0, busy=0, next grant goes to requester 0.
- Drive 16 words from requester 3 into the 16-deep FIFO with reads stopped: exactly 16 winc, 17th word stalls on wfull until a read frees space.
